// File: rtl/btn_conditioner.sv
// Front-panel button conditioner: synchronise, debounce, press/release pulses and per-channel
// auto-repeat, plus slide switches captured on the sample tick.
//   state | meaning
//   IDLE  | debounced level low
//   WAIT  | held, counting down the initial repeat delay
//   RPT   | held, stepping every REPEAT_RATE ticks
module btn_conditioner #(
    parameter int                 NUM_BTN        = 5,
    parameter int                 DIV_WIDTH      = 17,
    parameter int                 STABLE_SAMPLES = 3,
    parameter int                 REPEAT_DELAY   = 381,
    parameter int                 REPEAT_RATE    = 76,
    parameter logic [NUM_BTN-1:0] REPEAT_EN      = 5'b11110,
    parameter int                 SW_WIDTH       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTN-1:0]  i_btn,
    input  logic [SW_WIDTH-1:0] i_sw,
    output logic                o_tick,
    output logic [NUM_BTN-1:0]  o_level,
    output logic [NUM_BTN-1:0]  o_press,
    output logic [NUM_BTN-1:0]  o_release,
    output logic [NUM_BTN-1:0]  o_step,
    output logic [SW_WIDTH-1:0] o_sw
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RPT = 2'd2} state_t;

    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_tick;
    logic [NUM_BTN-1:0]   r_sync1;
    logic [NUM_BTN-1:0]   r_sync2;
    logic [SW_WIDTH-1:0]  r_sw;
    logic                 w_tk;

    assign w_tk = (r_div == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_tick  <= 1'b0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sw    <= '0;
        end else begin
            r_div   <= r_div + DIV_WIDTH'(1);
            r_tick  <= w_tk;
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (w_tk) r_sw <= i_sw;
        end
    end

    assign o_tick = r_tick;
    assign o_sw   = r_sw;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        logic [STABLE_SAMPLES-1:0] r_hist;
        logic [STABLE_SAMPLES-1:0] w_hist_next;
        logic                      r_level;
        logic                      r_press;
        logic                      r_release;
        logic                      r_rpt;
        state_t                    r_state;
        state_t                    w_state_next;
        logic [9:0]                r_rc;
        logic [9:0]                w_rc_next;
        logic                      w_rpt;
        logic                      w_rise;
        logic                      w_fall;

        // The level decision looks at the history including this tick's sample.
        assign w_hist_next = {r_hist[STABLE_SAMPLES-2:0], r_sync2[g]};
        assign w_rise      = w_tk & (&w_hist_next) & ~r_level;
        assign w_fall      = w_tk & ~(|w_hist_next) & r_level;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hist    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_rpt     <= 1'b0;
                r_state   <= S_IDLE;
                r_rc      <= '0;
            end else begin
                if (w_tk) r_hist <= w_hist_next;
                if (w_rise)      r_level <= 1'b1;
                else if (w_fall) r_level <= 1'b0;
                r_press   <= w_rise;
                r_release <= w_fall;
                r_rpt     <= w_rpt;
                r_state   <= w_state_next;
                r_rc      <= w_rc_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_rc_next    = r_rc;
            w_rpt        = 1'b0;
            if (w_fall) begin
                w_state_next = S_IDLE;
                w_rc_next    = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            w_state_next = S_WAIT;
                            w_rc_next    = 10'(REPEAT_DELAY);
                        end
                    end
                    S_WAIT, S_RPT: begin
                        // Reload at 1 so the counter never reaches 0 while held.
                        if (w_tk && REPEAT_EN[g]) begin
                            if (r_rc <= 10'd1) begin
                                w_rpt        = 1'b1;
                                w_rc_next    = 10'(REPEAT_RATE);
                                w_state_next = S_RPT;
                            end else begin
                                w_rc_next = r_rc - 10'd1;
                            end
                        end
                    end
                    default: w_state_next = S_IDLE;
                endcase
            end
        end

        assign o_level[g]   = r_level;
        assign o_press[g]   = r_press;
        assign o_release[g] = r_release;
        assign o_step[g]    = r_press | r_rpt;
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: tick-level reference model checked every cycle, a table of
// hold patterns with pulse counts, and hand sequences for bounce and async reset.
module tb_btn_conditioner;
    localparam int NB   = 5;
    localparam int DW   = 4;
    localparam int SS   = 3;
    localparam int RD   = 4;
    localparam int RR   = 2;
    localparam int SWW  = 8;
    localparam int TPER = 1 << DW;
    localparam logic [NB-1:0] REN = 5'b11110;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [NB-1:0]  i_btn = '0;
    logic [SWW-1:0] i_sw  = '0;
    logic           o_tick;
    logic [NB-1:0]  o_level, o_press, o_release, o_step;
    logic [SWW-1:0] o_sw;

    btn_conditioner #(
        .NUM_BTN(NB), .DIV_WIDTH(DW), .STABLE_SAMPLES(SS), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .REPEAT_EN(REN), .SW_WIDTH(SWW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .i_sw(i_sw), .o_tick(o_tick),
        .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_step(o_step), .o_sw(o_sw)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: clock edges since reset, raw pin history, per-tick sample history,
    // level and number of ticks a press has been held.
    int             m_n;
    logic [NB-1:0]  m_btn_q[$];
    logic [NB-1:0]  m_samp_q[$];
    logic [NB-1:0]  m_lvl;
    int             m_held[NB];
    logic           e_tick;
    logic [NB-1:0]  e_press, e_release, e_step;
    logic [SWW-1:0] e_sw;

    typedef struct {
        logic [NB-1:0] mask;
        int            hold;
        int            exp_press;
        int            exp_rel;
        int            exp_step;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, m_n, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_btn_q.delete();
        m_btn_q.push_back('0);
        m_btn_q.push_back('0);
        m_samp_q.delete();
        for (int s = 0; s < SS; s++) m_samp_q.push_back('0);
        m_lvl = '0;
        for (int c = 0; c < NB; c++) m_held[c] = 0;
        e_tick = 1'b0; e_press = '0; e_release = '0; e_step = '0; e_sw = '0;
    endtask

    task automatic model_edge();
        int ones;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_n++;
            m_btn_q.push_back(i_btn);
            if (m_btn_q.size() > 4) void'(m_btn_q.pop_front());
            e_tick = (m_n % TPER == 0);
            e_press = '0; e_release = '0; e_step = '0;
            if (e_tick) begin
                e_sw = i_sw;
                // Two synchroniser stages: the tick sees the pin as it was two edges ago.
                m_samp_q.push_back(m_btn_q[m_btn_q.size() - 3]);
                void'(m_samp_q.pop_front());
                for (int c = 0; c < NB; c++) begin
                    ones = 0;
                    for (int s = 0; s < SS; s++) ones += int'(m_samp_q[s][c]);
                    if (ones == SS && !m_lvl[c]) begin
                        m_lvl[c] = 1'b1; e_press[c] = 1'b1; e_step[c] = 1'b1; m_held[c] = 0;
                    end else if (ones == 0 && m_lvl[c]) begin
                        m_lvl[c] = 1'b0; e_release[c] = 1'b1;
                    end else if (m_lvl[c]) begin
                        m_held[c]++;
                        if (REN[c] && m_held[c] >= RD && (m_held[c] - RD) % RR == 0) e_step[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("tick",    32'(o_tick),    32'(e_tick));
        chk("level",   32'(o_level),   32'(m_lvl));
        chk("press",   32'(o_press),   32'(e_press));
        chk("release", 32'(o_release), 32'(e_release));
        chk("step",    32'(o_step),    32'(e_step));
        chk("sw",      32'(o_sw),      32'(e_sw));
    endtask

    task automatic align();
        do cyc(); while (m_n % TPER != 0);
    endtask

    initial begin
        int cp[NB], cr[NB], cs[NB];
        int coinc, cnt_p, cnt_r, cnt_s;

        vecs[0] = '{5'b00010,  6, 1, 1, 2};
        vecs[1] = '{5'b00100, 20, 1, 1, 9};
        vecs[2] = '{5'b00001, 20, 1, 1, 1};
        vecs[3] = '{5'b10001,  3, 1, 1, 1};
        vecs[4] = '{5'b01000,  2, 0, 0, 0};
        vecs[5] = '{5'b00100,  5, 1, 1, 2};
        vecs[6] = '{5'b00100,  4, 1, 1, 1};
        vecs[7] = '{5'b10000,  9, 1, 1, 4};

        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;

        // Reset state, tick spacing and a clean press/release on channel 1.
        for (int k = 1; k <= 160; k++) begin
            cyc();
            if (k == 1) begin
                chk("rst_tick",  32'(o_tick),  32'd0);
                chk("rst_level", 32'(o_level), 32'd0);
                chk("rst_step",  32'(o_step),  32'd0);
            end
            if (k == 16 || k == 32 || k == 48) chk("tick_hi", 32'(o_tick), 32'd1);
            if (k == 15 || k == 17) chk("tick_lo", 32'(o_tick), 32'd0);
            if (k == 47) chk("press_early", 32'(o_press[1]), 32'd0);
            if (k == 48) begin
                chk("press_48", 32'(o_press[1]), 32'd1);
                chk("step_48",  32'(o_step[1]),  32'd1);
            end
            if (k == 49) chk("press_width", 32'(o_press[1]), 32'd0);
            if (k == 60) chk("level_held", 32'(o_level[1]), 32'd1);
            if (k == 143) chk("release_early", 32'(o_release[1]), 32'd0);
            if (k == 144) chk("release_144", 32'(o_release[1]), 32'd1);
            if (k == 3)   i_btn[1] = 1'b1;
            if (k == 100) i_btn[1] = 1'b0;
        end

        // Bounce: channel 3 alternates every tick, never three equal samples.
        align();
        cnt_p = 0; cnt_r = 0;
        for (int t = 0; t < 8; t++) begin
            i_btn[3] = ~i_btn[3];
            repeat (TPER) begin
                cyc();
                cnt_p += $countones(o_press);
                cnt_r += $countones(o_release);
            end
        end
        chk("bounce_press",   32'(cnt_p),   32'd0);
        chk("bounce_release", 32'(cnt_r),   32'd0);
        chk("bounce_level",   32'(o_level), 32'd0);
        i_btn = '0;
        repeat (4 * TPER) cyc();

        // Table of hold patterns: pulse counts per channel.
        for (int v = 0; v < 8; v++) begin
            align();
            for (int c = 0; c < NB; c++) begin cp[c] = 0; cr[c] = 0; cs[c] = 0; end
            coinc = 0;
            i_btn = vecs[v].mask;
            for (int k = 0; k < (vecs[v].hold + 6) * TPER; k++) begin
                if (k == vecs[v].hold * TPER) i_btn = '0;
                cyc();
                for (int c = 0; c < NB; c++) begin
                    cp[c] += int'(o_press[c]);
                    cr[c] += int'(o_release[c]);
                    cs[c] += int'(o_step[c]);
                end
                if (o_press == vecs[v].mask) coinc++;
            end
            for (int c = 0; c < NB; c++) begin
                chk($sformatf("vec%0d_press_ch%0d", v, c),   32'(cp[c]), vecs[v].mask[c] ? 32'(vecs[v].exp_press) : 32'd0);
                chk($sformatf("vec%0d_release_ch%0d", v, c), 32'(cr[c]), vecs[v].mask[c] ? 32'(vecs[v].exp_rel)   : 32'd0);
                chk($sformatf("vec%0d_step_ch%0d", v, c),    32'(cs[c]), vecs[v].mask[c] ? 32'(vecs[v].exp_step)  : 32'd0);
            end
            chk($sformatf("vec%0d_coincident", v), 32'(coinc), 32'(vecs[v].exp_press));
        end

        // Async reset while channel 2 is repeating, button kept held afterwards.
        align();
        i_sw  = 8'hA5;
        i_btn = 5'b00100;
        repeat (8 * TPER + 5) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tick",    32'(o_tick),    32'd0);
        chk("arst_level",   32'(o_level),   32'd0);
        chk("arst_press",   32'(o_press),   32'd0);
        chk("arst_release", 32'(o_release), 32'd0);
        chk("arst_step",    32'(o_step),    32'd0);
        chk("arst_sw",      32'(o_sw),      32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        cnt_s = 0;
        for (int k = 1; k <= 50; k++) begin
            cyc();
            if (k < 48) cnt_s += $countones(o_step);
            if (k == 47) chk("arst_press_early", 32'(o_press[2]), 32'd0);
            if (k == 48) chk("arst_press_48",    32'(o_press[2]), 32'd1);
        end
        chk("arst_no_trailing_step", 32'(cnt_s), 32'd0);
        i_btn = '0;
        repeat (4 * TPER) cyc();

        // Randomised pins and switches against the reference model.
        for (int seg = 0; seg < 80; seg++) begin
            int dur;
            i_btn = NB'($urandom);
            i_sw  = SWW'($urandom);
            dur   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 400)) : int'($urandom_range(1, 40));
            repeat (dur) cyc();
        end
        i_btn = '0;
        repeat (5 * TPER) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
